// File: rtl/sipo_ctrl_pkg.sv
// rtl/sipo_ctrl_pkg.sv - shared types and default sizes for the SIPO frame sequencer
package sipo_ctrl_pkg;

    localparam int DEF_WIDTH = 32;
    localparam int DEF_CNT_W = 6;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        PAR   = 2'd2,
        HOLD  = 2'd3
    } state_t;

endpackage

// File: rtl/sipo_shift_en.sv
// rtl/sipo_shift_en.sv - WIDTH-bit MSB-first shift register with enable and sync active-low clear
module sipo_shift_en #(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             clr_n,
    input  logic             en,
    input  logic             din,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge clock) begin
        if (!clr_n) begin
            q <= '0;
        end else if (en) begin
            q <= {q[WIDTH-2:0], din};
        end
    end

endmodule

// File: rtl/sipo_frame_ctrl.sv
// rtl/sipo_frame_ctrl.sv - frame sequencer for the serial-in/parallel-out capture path
// Optional parity bit per frame when PARITY_CHECK_EN is defined.
module sipo_frame_ctrl
    import sipo_ctrl_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             clock,
    input  logic             rst,
    input  logic             frame_start,
    input  logic             din,
    input  logic             din_valid,
    input  logic             word_ready,
    output logic             word_valid,
    output logic [WIDTH-1:0] word,
    output logic             busy,
    output logic [CNT_W-1:0] bit_cnt,
    output logic             frame_err,
    output logic             overrun,
    output logic             parity_err
);

    state_t state;
    logic   shift_en;
    logic   last_bit;

    // A restart strobe takes priority over a coincident data bit, so that bit is dropped.
    assign shift_en = (state == SHIFT) && din_valid && !frame_start;
    assign last_bit = (bit_cnt == CNT_W'(WIDTH - 1));

    sipo_shift_en #(
        .WIDTH(WIDTH)
    ) u_shift (
        .clock (clock),
        .clr_n (rst),
        .en    (shift_en),
        .din   (din),
        .q     (word)
    );

`ifdef PARITY_CHECK_EN
    logic parity_q;
    assign parity_err = parity_q;
`else
    assign parity_err = 1'b0;
`endif

    always_ff @(posedge clock) begin
        if (!rst) begin
            state      <= IDLE;
            bit_cnt    <= '0;
            word_valid <= 1'b0;
            busy       <= 1'b0;
            frame_err  <= 1'b0;
            overrun    <= 1'b0;
`ifdef PARITY_CHECK_EN
            parity_q   <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (frame_start) begin
                        state   <= SHIFT;
                        bit_cnt <= '0;
                        busy    <= 1'b1;
                    end
                end
                SHIFT: begin
                    if (frame_start) begin
                        frame_err <= 1'b1;
                        bit_cnt   <= '0;
                    end else if (din_valid) begin
                        bit_cnt <= bit_cnt + 1'b1;
                        if (last_bit) begin
`ifdef PARITY_CHECK_EN
                            state      <= PAR;
`else
                            state      <= HOLD;
                            word_valid <= 1'b1;
`endif
                        end
                    end
                end
`ifdef PARITY_CHECK_EN
                PAR: begin
                    if (frame_start) begin
                        frame_err <= 1'b1;
                        bit_cnt   <= '0;
                        state     <= SHIFT;
                    end else if (din_valid) begin
                        state      <= HOLD;
                        word_valid <= 1'b1;
                        parity_q   <= ^{word, din};
                    end
                end
`endif
                HOLD: begin
                    if (word_ready) begin
                        word_valid <= 1'b0;
                        if (frame_start) begin
                            state   <= SHIFT;
                            bit_cnt <= '0;
                        end else begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end
                    end else if (frame_start) begin
                        overrun <= 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sipo_frame_ctrl.sv
// tb/tb_sipo_frame_ctrl.sv - randomized and directed self-checking bench for sipo_frame_ctrl
module tb_sipo_frame_ctrl;

    localparam int WIDTH = 32;
    localparam int CNT_W = 6;
`ifdef PARITY_CHECK_EN
    localparam int FLEN = WIDTH + 1;
`else
    localparam int FLEN = WIDTH;
`endif

    logic             clock = 1'b0;
    logic             rst;
    logic             frame_start;
    logic             din;
    logic             din_valid;
    logic             word_ready;
    logic             word_valid;
    logic [WIDTH-1:0] word;
    logic             busy;
    logic [CNT_W-1:0] bit_cnt;
    logic             frame_err;
    logic             overrun;
    logic             parity_err;

    int n_vec = 0;
    int n_err = 0;

    // Reference view: a frame is "in progress" with some number of captured bits; it is
    // complete (waiting for the consumer) once FLEN bits have arrived.
    bit               m_in;
    int               m_nbits;
    logic [WIDTH-1:0] m_word;
    bit               m_ferr;
    bit               m_ovr;
    bit               m_par;

    always #5 clock = ~clock;

    sipo_frame_ctrl #(
        .WIDTH(WIDTH),
        .CNT_W(CNT_W)
    ) dut (
        .clock       (clock),
        .rst         (rst),
        .frame_start (frame_start),
        .din         (din),
        .din_valid   (din_valid),
        .word_ready  (word_ready),
        .word_valid  (word_valid),
        .word        (word),
        .busy        (busy),
        .bit_cnt     (bit_cnt),
        .frame_err   (frame_err),
        .overrun     (overrun),
        .parity_err  (parity_err)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_update(input bit r, input bit fs, input bit dv, input bit d, input bit wr);
        bit complete;
        complete = m_in && (m_nbits == FLEN);
        if (!r) begin
            m_in = 0; m_nbits = 0; m_word = '0; m_ferr = 0; m_ovr = 0; m_par = 0;
        end else if (complete) begin
            if (wr) begin
                if (fs) m_nbits = 0;
                else    m_in = 0;
            end else if (fs) begin
                m_ovr = 1;
            end
        end else if (m_in) begin
            if (fs) begin
                m_ferr  = 1;
                m_nbits = 0;
            end else if (dv) begin
                if (m_nbits < WIDTH) m_word = m_word * 2 + WIDTH'(d);
                else                 m_par = (^m_word) ^ d;
                m_nbits++;
            end
        end else if (fs) begin
            m_in    = 1;
            m_nbits = 0;
        end
    endtask

    task automatic compare_all();
        int cnt;
        cnt = (m_nbits > WIDTH) ? WIDTH : m_nbits;
        check("word_valid", word_valid, m_in && (m_nbits == FLEN));
        check("word",       word,       m_word);
        check("busy",       busy,       m_in);
        check("bit_cnt",    bit_cnt,    cnt);
        check("frame_err",  frame_err,  m_ferr);
        check("overrun",    overrun,    m_ovr);
`ifdef PARITY_CHECK_EN
        check("parity_err", parity_err, m_par);
`else
        check("parity_err", parity_err, 1'b0);
`endif
    endtask

    task automatic step(input bit r, input bit fs, input bit dv, input bit d, input bit wr);
        rst = r; frame_start = fs; din_valid = dv; din = d; word_ready = wr;
        @(posedge clock);
        model_update(r, fs, dv, d, wr);
        @(negedge clock);
        compare_all();
    endtask

    task automatic send_bits(input logic [WIDTH-1:0] v, input int n, input bit gaps, input bit wr);
        int k;
        k = 0;
        for (int i = WIDTH - 1; i >= WIDTH - n; i--) begin
            if (gaps && (k % 3 == 2)) step(1, 0, 0, 1'($urandom), wr);
            step(1, 0, 1, v[i], wr);
            k++;
        end
    endtask

    task automatic send_parity(input logic [WIDTH-1:0] v, input bit pbit, input bit wr);
`ifdef PARITY_CHECK_EN
        step(1, 0, 1, pbit, wr);
`else
        if (pbit && (v == '0)) step(1, 0, 0, 0, wr);
`endif
    endtask

    initial begin
        m_in = 0; m_nbits = 0; m_word = '0; m_ferr = 0; m_ovr = 0; m_par = 0;
        rst = 0; frame_start = 0; din = 0; din_valid = 0; word_ready = 0;

        step(0, 0, 0, 0, 0);
        step(0, 1, 1, 1, 1);
        check("reset_busy", busy, 1'b0);
        check("reset_word", word, '0);

        // Reset in the middle of a frame
        step(1, 1, 0, 0, 0);
        send_bits(32'h1234_5678, 17, 0, 0);
        check("t1_bit_cnt", bit_cnt, 17);
        step(0, 0, 1, 1, 0);
        step(0, 1, 1, 1, 1);
        check("t1_word", word, '0);
        check("t1_bit_cnt_rst", bit_cnt, 0);
        step(1, 0, 1, 1, 1);
        check("t1_idle", busy, 1'b0);

        // Plain frame, consumer always ready
        step(1, 1, 0, 0, 1);
        send_bits(32'hA5A5_F00F, WIDTH, 0, 1);
        send_parity(32'hA5A5_F00F, 0, 1);
        check("t2_valid", word_valid, 1'b1);
        check("t2_word", word, 32'hA5A5_F00F);
        step(1, 0, 0, 0, 1);
        check("t2_valid_fall", word_valid, 1'b0);
        check("t2_busy_fall", busy, 1'b0);

        // Same frame with gaps in din_valid
        step(1, 1, 0, 0, 1);
        send_bits(32'hA5A5_F00F, WIDTH, 1, 1);
        send_parity(32'hA5A5_F00F, 0, 1);
        check("t3_word", word, 32'hA5A5_F00F);
        check("t3_valid", word_valid, 1'b1);

        // Consumer stalls, start during HOLD, then back-to-back start
        for (int c = 0; c < 5; c++) step(1, (c == 1), 1, 1, 0);
        check("t4_overrun", overrun, 1'b1);
        check("t4_word_stable", word, 32'hA5A5_F00F);
        step(1, 1, 0, 0, 1);
        check("t4_b2b_busy", busy, 1'b1);
        check("t4_b2b_valid", word_valid, 1'b0);

        // Restart mid-frame
        send_bits(32'hFFFF_FFFF, 10, 0, 0);
        step(1, 1, 0, 0, 0);
        check("t5_frame_err", frame_err, 1'b1);
        check("t5_bit_cnt", bit_cnt, 0);
        send_bits(32'h0000_0001, WIDTH, 0, 0);
        send_parity(32'h0000_0001, 1, 0);
        check("t5_word", word, 32'h0000_0001);
        step(1, 0, 0, 0, 1);

`ifdef PARITY_CHECK_EN
        step(1, 1, 0, 0, 0);
        send_bits(32'hFFFF_FFFF, WIDTH, 0, 0);
        send_parity(32'hFFFF_FFFF, 1, 0);
        check("t6_parity_one", parity_err, 1'b1);
        step(1, 1, 0, 0, 1);
        send_bits(32'hFFFF_FFFF, WIDTH, 0, 0);
        send_parity(32'hFFFF_FFFF, 0, 0);
        check("t6_parity_zero", parity_err, 1'b0);
        step(1, 0, 0, 0, 1);
`endif

        // Random traffic against the reference model
        for (int i = 0; i < 4000; i++) begin
            step(($urandom_range(0, 299) != 0),
                 ($urandom_range(0, 59) == 0),
                 ($urandom_range(0, 3) != 0),
                 1'($urandom),
                 ($urandom_range(0, 2) != 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
